// File: rtl/ack_bus_pkg.sv
// Shared types and constants for the sequential ACK bus arbiter.
package ack_bus_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRelease
  } state_e;

  // Source IDs for the 4-source configuration.
  localparam int unsigned ID_MEM  = 0;
  localparam int unsigned ID_SHA  = 1;
  localparam int unsigned ID_AES  = 2;
  localparam int unsigned ID_CTRL = 3;

endpackage

// File: rtl/ack_rr_pick.sv
// Combinational winner picker: lowest-index first (mode=0) or round-robin
// scan starting just after ptr (mode=1).
module ack_rr_pick #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             mode,
  output logic             valid,
  output logic [ID_W-1:0]  winner,
  output logic [N_SRC-1:0] onehot
);

  int unsigned     pos;
  logic [ID_W-1:0] idx;

  // Scan candidates in priority order; the first requester found wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    onehot = '0;
    pos    = 0;
    idx    = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      pos = mode ? ((32'(ptr) + 32'd1 + i) % N_SRC) : i;
      idx = ID_W'(pos);
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        winner      = idx;
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ack_bus_arbiter_seq.sv
// Registered ACK bus arbiter: one-hot grant held until the winner drops its
// request or the hold timeout fires, with a one-cycle release gap between grants.
module ack_bus_arbiter_seq
  import ack_bus_pkg::*;
#(
  parameter int unsigned N_SRC    = 4,
  parameter int unsigned ID_W     = $clog2(N_SRC),
  parameter int unsigned RR_MODE  = 0,
  parameter int unsigned MAX_HOLD = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] ack_ready,
  output logic [ID_W-1:0]  winner_source_id,
  output logic             ack_event,
  output logic             busy,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] grant_count,
  output logic             ack_valid_n_bus_o,
  output logic [ID_W-1:0]  ack_id_bus_o
);

  // Wide enough to hold MAX_HOLD; at least one bit when the timeout is disabled.
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 2);

  state_e           state_q, state_d;
  logic [N_SRC-1:0] ack_ready_q, ack_ready_d;
  logic [ID_W-1:0]  winner_q, winner_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             ack_event_q, ack_event_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic             pick_valid;
  logic [ID_W-1:0]  pick_id;
  logic [N_SRC-1:0] pick_onehot;
  logic             hold_last;

  ack_rr_pick #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .mode   (RR_MODE != 0),
    .valid  (pick_valid),
    .winner (pick_id),
    .onehot (pick_onehot)
  );

  // Current GRANT cycle is the MAX_HOLD-th one.
  assign hold_last = (hold_q + HoldW'(1)) == HoldW'(MAX_HOLD);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ack_ready_q <= '0;
      winner_q    <= '0;
      rr_ptr_q    <= ID_W'(N_SRC - 1);
      ack_event_q <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      ack_ready_q <= ack_ready_d;
      winner_q    <= winner_d;
      rr_ptr_q    <= rr_ptr_d;
      ack_event_q <= ack_event_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold in GRANT, one gap cycle in RELEASE.
  always_comb begin
    state_d     = state_q;
    ack_ready_d = ack_ready_q;
    winner_d    = winner_q;
    rr_ptr_d    = rr_ptr_q;
    ack_event_d = 1'b0;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d     = StGrant;
          ack_ready_d = pick_onehot;
          winner_d    = pick_id;
          rr_ptr_d    = pick_id;
          ack_event_d = 1'b1;
          hold_d      = '0;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StGrant: begin
        hold_d = hold_q + HoldW'(1);
        // Only the winner's own request matters; other requesters never preempt.
        if (!req[winner_q]) begin
          state_d     = StRelease;
          ack_ready_d = '0;
        end else if ((MAX_HOLD != 0) && hold_last) begin
          state_d     = StRelease;
          ack_ready_d = '0;
          timeout_d   = 1'b1;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d     = StIdle;
        ack_ready_d = '0;
      end
    endcase
  end

  // Registered outputs.
  always_comb begin
    ack_ready        = ack_ready_q;
    winner_source_id = winner_q;
    ack_event        = ack_event_q;
    busy             = (state_q != StIdle);
    timeout_flag     = timeout_q;
    grant_count      = cnt_q;
  end

  // Wired-AND image of the open-drain bus, straight from req.
  always_comb begin
    ack_valid_n_bus_o = ~|req;
    ack_id_bus_o      = '1;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (req[ID_W'(i)]) ack_id_bus_o = ack_id_bus_o & ID_W'(i);
    end
  end

endmodule

// File: tb/tb_ack_bus_arbiter_seq.sv
// Directed bench for ack_bus_arbiter_seq: a fixed-priority instance with a short
// hold timeout and 2-bit counter, and a round-robin instance with defaults.
module tb_ack_bus_arbiter_seq;
  import ack_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_a, req_b;

  logic [3:0] ack_a, ack_b;
  logic [1:0] win_a, win_b;
  logic       ev_a, ev_b, busy_a, busy_b, to_a, to_b;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;
  logic       vn_a, vn_b;
  logic [1:0] idb_a, idb_b;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  ack_bus_arbiter_seq #(
    .N_SRC    (4),
    .RR_MODE  (0),
    .MAX_HOLD (4),
    .CNT_W    (2)
  ) u_fp (
    .clk               (clk),
    .rst_n             (rst_n),
    .req               (req_a),
    .ack_ready         (ack_a),
    .winner_source_id  (win_a),
    .ack_event         (ev_a),
    .busy              (busy_a),
    .timeout_flag      (to_a),
    .grant_count       (cnt_a),
    .ack_valid_n_bus_o (vn_a),
    .ack_id_bus_o      (idb_a)
  );

  ack_bus_arbiter_seq #(
    .N_SRC   (4),
    .RR_MODE (1)
  ) u_rr (
    .clk               (clk),
    .rst_n             (rst_n),
    .req               (req_b),
    .ack_ready         (ack_b),
    .winner_source_id  (win_b),
    .ack_event         (ev_b),
    .busy              (busy_b),
    .timeout_flag      (to_b),
    .grant_count       (cnt_b),
    .ack_valid_n_bus_o (vn_b),
    .ack_id_bus_o      (idb_b)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] onehot;
    logic [1:0] id;
    logic       vn;
    logic [1:0] idbus;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_oh;
    int unsigned w;

    // req, grant onehot, winner, valid_n image, id image
    vecs[0] = '{4'b0110, 4'b0010, 2'd1, 1'b0, 2'b00};
    vecs[1] = '{4'b0001, 4'b0001, 2'd0, 1'b0, 2'b00};
    vecs[2] = '{4'b0010, 4'b0010, 2'd1, 1'b0, 2'b01};
    vecs[3] = '{4'b0100, 4'b0100, 2'd2, 1'b0, 2'b10};
    vecs[4] = '{4'b1000, 4'b1000, 2'd3, 1'b0, 2'b11};
    vecs[5] = '{4'b1010, 4'b0010, 2'd1, 1'b0, 2'b01};
    vecs[6] = '{4'b1100, 4'b0100, 2'd2, 1'b0, 2'b10};
    vecs[7] = '{4'b1110, 4'b0010, 2'd1, 1'b0, 2'b00};
    vecs[8] = '{4'b1111, 4'b0001, 2'd0, 1'b0, 2'b00};
    vecs[9] = '{4'b1001, 4'b0001, 2'd0, 1'b0, 2'b00};

    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    repeat (2) tick();
    check("rst_ack_ready", 32'(ack_a), 32'h0);
    check("rst_winner", 32'(win_a), 32'h0);
    check("rst_ack_event", 32'(ev_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_timeout", 32'(to_a), 32'h0);
    check("rst_count", 32'(cnt_a), 32'h0);
    check("idle_valid_n", 32'(vn_a), 32'h1);
    check("idle_id_bus", 32'(idb_a), 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_no_grant", 32'(ack_a), 32'h0);

    // Table: first grant from IDLE, debug bus image, saturating grant count.
    for (int i = 0; i < 10; i++) begin
      req_a = vecs[i].req;
      #1;
      check($sformatf("v%0d_valid_n", i), 32'(vn_a), 32'(vecs[i].vn));
      check($sformatf("v%0d_id_bus", i), 32'(idb_a), 32'(vecs[i].idbus));
      check($sformatf("v%0d_pre_ack", i), 32'(ack_a), 32'h0);
      tick();
      check($sformatf("v%0d_ack_ready", i), 32'(ack_a), 32'(vecs[i].onehot));
      check($sformatf("v%0d_winner", i), 32'(win_a), 32'(vecs[i].id));
      check($sformatf("v%0d_event", i), 32'(ev_a), 32'h1);
      check($sformatf("v%0d_count", i), 32'(cnt_a), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      tick();
      check($sformatf("v%0d_hold", i), 32'(ack_a), 32'(vecs[i].onehot));
      check($sformatf("v%0d_event_off", i), 32'(ev_a), 32'h0);
      req_a = '0;
      tick();
      check($sformatf("v%0d_release", i), 32'(ack_a), 32'h0);
      check($sformatf("v%0d_busy_rel", i), 32'(busy_a), 32'h1);
      tick();
      check($sformatf("v%0d_idle", i), 32'(busy_a), 32'h0);
    end

    // No preemption: source 2 holds while source 0 rises.
    req_a = 4'b0100;
    tick();
    check("np_grant", 32'(ack_a), 32'h4);
    check("np_winner", 32'(win_a), ID_AES);
    req_a = 4'b0101;
    tick();
    check("np_hold1", 32'(ack_a), 32'h4);
    tick();
    check("np_hold2", 32'(ack_a), 32'h4);
    req_a = 4'b0001;
    tick();
    check("np_release", 32'(ack_a), 32'h0);
    tick();
    check("np_idle", 32'(ack_a), 32'h0);
    tick();
    check("np_regrant", 32'(ack_a), 32'h1);
    check("np_regrant_id", 32'(win_a), ID_MEM);
    check("np_regrant_ev", 32'(ev_a), 32'h1);
    req_a = '0;
    repeat (2) tick();

    // Hold timeout: source 3 never lets go.
    req_a = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("to_hold%0d", c), 32'(ack_a), 32'h8);
      check($sformatf("to_flag_pre%0d", c), 32'(to_a), 32'h0);
    end
    tick();
    check("to_release", 32'(ack_a), 32'h0);
    check("to_flag", 32'(to_a), 32'h1);
    tick();
    check("to_idle", 32'(ack_a), 32'h0);
    tick();
    check("to_regrant", 32'(ack_a), 32'h8);
    check("to_regrant_id", 32'(win_a), ID_CTRL);
    check("to_regrant_ev", 32'(ev_a), 32'h1);
    req_a = '0;
    repeat (3) tick();
    check("to_flag_sticky", 32'(to_a), 32'h1);

    // Asynchronous reset in the grant cycle, checked before the next edge.
    req_a = 4'b0010;
    tick();
    check("ar_grant", 32'(ack_a), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ack_ready", 32'(ack_a), 32'h0);
    check("ar_event", 32'(ev_a), 32'h0);
    check("ar_busy", 32'(busy_a), 32'h0);
    check("ar_count", 32'(cnt_a), 32'h0);
    check("ar_timeout", 32'(to_a), 32'h0);
    req_a = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Round-robin: all requesting, each winner drops for one cycle.
    req_b = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      w      = k % 4;
      exp_oh = 4'b0001 << w;
      tick();
      check($sformatf("rr%0d_grant", k), 32'(ack_b), 32'(exp_oh));
      check($sformatf("rr%0d_winner", k), 32'(win_b), w);
      check($sformatf("rr%0d_event", k), 32'(ev_b), 32'h1);
      tick();
      check($sformatf("rr%0d_hold", k), 32'(ack_b), 32'(exp_oh));
      check($sformatf("rr%0d_event_off", k), 32'(ev_b), 32'h0);
      req_b = 4'b1111 & ~exp_oh;
      tick();
      check($sformatf("rr%0d_release", k), 32'(ack_b), 32'h0);
      req_b = 4'b1111;
      tick();
      check($sformatf("rr%0d_idle", k), 32'(ack_b), 32'h0);
    end
    check("rr_count", 32'(cnt_b), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
